axil_sig_dump: RTL and testbench

//  Synthesizable end-of-test signature unit for compliance runs. Counts cycles until the core

---
 rtl/axil_sig_dump.sv | 160 ++++++++++++++++
 tb/tb_axil_sig_dump.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_sig_dump.sv
// End-of-test signature dumper: waits for halt or timeout, then reads [sig_begin, sig_end)
// over an AXI-Lite read-only master and streams each word out with a last flag.
module axil_sig_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  halt,
    input  logic [CNT_WIDTH-1:0]  timeout_limit,
    input  logic [ADDR_WIDTH-1:0] sig_begin,
    input  logic [ADDR_WIDTH-1:0] sig_end,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [DATA_WIDTH-1:0] sig_tdata,
    output logic                  sig_tvalid,
    input  logic                  sig_tready,
    output logic                  sig_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  rd_err,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_WIDTH);

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_curAddr;
    logic [ADDR_WIDTH-1:0] r_endAddr;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [CNT_WIDTH-1:0]  r_cycleCount;
    logic                  r_timedOut;
    logic                  r_rdErr;

    logic [ADDR_WIDTH-1:0] w_beginAligned;
    logic [ADDR_WIDTH-1:0] w_endAligned;
    logic [ADDR_WIDTH-1:0] w_nextAddr;
    logic                  w_timeoutHit;
    logic                  w_trigger;
    logic                  w_isLast;

    assign w_beginAligned = sig_begin & ALIGN_MASK;
    assign w_endAligned   = sig_end & ALIGN_MASK;
    assign w_nextAddr     = r_curAddr + ADDR_STEP;
    assign w_isLast       = (w_nextAddr >= r_endAddr);
    // The timeout fires on the IDLE cycle whose pre-increment count is limit-1.
    assign w_timeoutHit   = (timeout_limit != '0) &&
                            (r_cycleCount == (timeout_limit - CNT_WIDTH'(1)));
    assign w_trigger      = halt || w_timeoutHit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_nextState = (w_endAligned <= w_beginAligned) ? S_DONE : S_AR;
                end
            end
            S_AR: begin
                if (m_axil_arready) begin
                    w_nextState = S_R;
                end
            end
            S_R: begin
                if (m_axil_rvalid) begin
                    w_nextState = S_OUT;
                end
            end
            S_OUT: begin
                if (sig_tready) begin
                    w_nextState = w_isLast ? S_DONE : S_AR;
                end
            end
            S_DONE: begin
                w_nextState = S_DONE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_curAddr    <= '0;
            r_endAddr    <= '0;
            r_tdata      <= '0;
            r_cycleCount <= '0;
            r_timedOut   <= 1'b0;
            r_rdErr      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cycleCount != '1) begin
                        r_cycleCount <= r_cycleCount + CNT_WIDTH'(1);
                    end
                    if (w_trigger) begin
                        r_curAddr  <= w_beginAligned;
                        r_endAddr  <= w_endAligned;
                        r_timedOut <= !halt;
                    end
                end
                S_R: begin
                    if (m_axil_rvalid) begin
                        r_tdata <= m_axil_rdata;
                        r_rdErr <= r_rdErr | (m_axil_rresp != 2'b00);
                    end
                end
                S_OUT: begin
                    if (sig_tready) begin
                        r_curAddr <= w_nextAddr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_axil_araddr  = r_curAddr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (r_state == S_AR);
    assign m_axil_rready  = (r_state == S_R);
    assign sig_tdata      = r_tdata;
    assign sig_tvalid     = (r_state == S_OUT);
    assign sig_tlast      = (r_state == S_OUT) && w_isLast;
    assign busy           = (r_state == S_AR) || (r_state == S_R) || (r_state == S_OUT);
    assign done           = (r_state == S_DONE);
    assign timed_out      = r_timedOut;
    assign rd_err         = r_rdErr;
    assign cycle_count    = r_cycleCount;

endmodule

// File: tb/tb_axil_sig_dump.sv
// Randomized bench for axil_sig_dump: an AXI-Lite slave / stream sink agent with random stalls
// plus a word-list reference model of the expected dump.
module tb_axil_sig_dump;

    logic        clk;
    logic        rstn;
    logic        halt;
    logic [31:0] timeout_limit;
    logic [31:0] sig_begin;
    logic [31:0] sig_end;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;
    logic [31:0] sig_tdata;
    logic        sig_tvalid;
    logic        sig_tready;
    logic        sig_tlast;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        rd_err;
    logic [31:0] cycle_count;

    axil_sig_dump dut (
        .clk           (clk),
        .rstn          (rstn),
        .halt          (halt),
        .timeout_limit (timeout_limit),
        .sig_begin     (sig_begin),
        .sig_end       (sig_end),
        .m_axil_araddr (m_axil_araddr),
        .m_axil_arprot (m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata  (m_axil_rdata),
        .m_axil_rresp  (m_axil_rresp),
        .m_axil_rvalid (m_axil_rvalid),
        .m_axil_rready (m_axil_rready),
        .sig_tdata     (sig_tdata),
        .sig_tvalid    (sig_tvalid),
        .sig_tready    (sig_tready),
        .sig_tlast     (sig_tlast),
        .busy          (busy),
        .done          (done),
        .timed_out     (timed_out),
        .rd_err        (rd_err),
        .cycle_count   (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int errorCount = 0;

    // Agent knobs, set by the main sequence before each dump
    int          arMin = 0, arMax = 0, rMin = 0, rMax = 0, tMin = 0, tMax = 0;
    int          errPct = 0;
    int          errIdx = -1;
    logic [31:0] memSeed = 32'h0;

    // Observations collected by the agent
    logic [31:0] addrQ[$];
    logic [31:0] dataQ[$];
    logic        lastQ[$];
    logic [1:0]  respQ[$];
    bit          sawAr, sawT;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ memSeed;
    endfunction

    // AXI-Lite slave and stream sink; every handshake is decided at a negedge for the next posedge
    initial begin : busAgent
        int          arCnt, arDelay, rCnt, rDelay, tCnt, tDelay, respIdx;
        bit          readPending, arHold, tHold;
        logic [31:0] pendAddr, heldAraddr, heldTdata;
        logic [1:0]  pendResp;
        logic        heldTlast;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = 2'b00;
        sig_tready     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_axil_arready = 1'b0;
                m_axil_rvalid  = 1'b0;
                m_axil_rdata   = '0;
                m_axil_rresp   = 2'b00;
                sig_tready     = 1'b0;
                readPending = 0; arHold = 0; tHold = 0;
                arCnt = 0; rCnt = 0; tCnt = 0; respIdx = 0;
                arDelay = $urandom_range(arMax, arMin);
                rDelay  = $urandom_range(rMax, rMin);
                tDelay  = $urandom_range(tMax, tMin);
                addrQ.delete(); dataQ.delete(); lastQ.delete(); respQ.delete();
                sawAr = 0; sawT = 0;
                continue;
            end
            m_axil_rvalid = 1'b0;
            m_axil_rresp  = 2'b00;
            if (readPending) begin
                if (rCnt >= rDelay) begin
                    m_axil_rvalid = 1'b1;
                    m_axil_rdata  = memWord(pendAddr);
                    m_axil_rresp  = pendResp;
                    if (m_axil_rready) readPending = 0;
                end else begin
                    rCnt++;
                end
            end
            m_axil_arready = 1'b0;
            if (m_axil_arvalid) begin
                sawAr = 1;
                if (arHold) checkOutput("araddrStable", m_axil_araddr, heldAraddr);
                if (arCnt >= arDelay) begin
                    m_axil_arready = 1'b1;
                    addrQ.push_back(m_axil_araddr);
                    pendAddr = m_axil_araddr;
                    if (respIdx == errIdx) pendResp = 2'b10;
                    else if ($urandom_range(99, 0) < errPct) pendResp = 2'($urandom_range(3, 1));
                    else pendResp = 2'b00;
                    respIdx++;
                    respQ.push_back(pendResp);
                    readPending = 1;
                    rCnt = 0;
                    rDelay = $urandom_range(rMax, rMin);
                    arCnt = 0;
                    arDelay = $urandom_range(arMax, arMin);
                    arHold = 0;
                end else begin
                    arCnt++;
                    arHold = 1;
                    heldAraddr = m_axil_araddr;
                end
            end
            sig_tready = 1'b0;
            if (sig_tvalid) begin
                sawT = 1;
                if (tHold) begin
                    checkOutput("tdataStable", sig_tdata, heldTdata);
                    checkOutput("tlastStable", sig_tlast, heldTlast);
                end
                if (tCnt >= tDelay) begin
                    sig_tready = 1'b1;
                    dataQ.push_back(sig_tdata);
                    lastQ.push_back(sig_tlast);
                    tCnt = 0;
                    tDelay = $urandom_range(tMax, tMin);
                    tHold = 0;
                end else begin
                    tCnt++;
                    tHold = 1;
                    heldTdata = sig_tdata;
                    heldTlast = sig_tlast;
                end
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_flags"},
                    {m_axil_arvalid, m_axil_rready, sig_tvalid, sig_tlast, busy, done, timed_out, rd_err},
                    8'h00);
        checkOutput({tag, "_araddr"}, m_axil_araddr, 32'h0);
        checkOutput({tag, "_arprot"}, m_axil_arprot, 3'b000);
        checkOutput({tag, "_tdata"}, sig_tdata, 32'h0);
        checkOutput({tag, "_count"}, cycle_count, 32'h0);
    endtask

    task automatic applyReset();
        rstn = 1'b0;
        halt = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Runs one complete dump from reset and checks it against the word-list model
    task automatic applyStimulus(input logic [31:0] beginA, input logic [31:0] endA,
                                 input int haltAt, input int limit);
        int          cyc, doneCyc, trig, expN;
        bit          expTimed, expErr;
        logic [31:0] a, e;
        logic [31:0] expAddr[$];
        logic        expLast[$];
        sig_begin     = beginA;
        sig_end       = endA;
        timeout_limit = limit;
        memSeed       = $urandom;
        applyReset();
        rstn = 1'b1;
        cyc = 0;
        doneCyc = -1;
        while (cyc < 3000) begin
            if (haltAt != 0 && cyc == haltAt - 1) halt = 1'b1;
            @(negedge clk);
            cyc++;
            if (done) begin
                doneCyc = cyc;
                break;
            end
        end
        checkOutput("doneWait", done, 1'b1);

        if (haltAt == 0) trig = limit;
        else if (limit == 0) trig = haltAt;
        else trig = (haltAt <= limit) ? haltAt : limit;
        expTimed = (limit != 0) && (haltAt == 0 || limit < haltAt);
        a = beginA & ~32'h3;
        e = endA & ~32'h3;
        for (logic [31:0] x = a; x < e; x += 4) begin
            expAddr.push_back(x);
            expLast.push_back(x + 4 >= e);
        end
        expN = expAddr.size();

        checkOutput("wordCount", dataQ.size(), expN);
        checkOutput("readCount", addrQ.size(), expN);
        for (int i = 0; i < expN; i++) begin
            if (i < addrQ.size()) checkOutput($sformatf("araddr[%0d]", i), addrQ[i], expAddr[i]);
            if (i < dataQ.size()) begin
                checkOutput($sformatf("tdata[%0d]", i), dataQ[i], memWord(expAddr[i]));
                checkOutput($sformatf("tlast[%0d]", i), lastQ[i], expLast[i]);
            end
        end
        expErr = 0;
        foreach (respQ[i]) if (respQ[i] != 2'b00) expErr = 1;
        checkOutput("timedOut", timed_out, expTimed);
        checkOutput("cycleCount", cycle_count, trig);
        checkOutput("rdErr", rd_err, expErr);
        checkOutput("busyAfterDone", busy, 1'b0);
        if (expN == 0) begin
            checkOutput("emptyNoAr", sawAr, 1'b0);
            checkOutput("emptyNoT", sawT, 1'b0);
            checkOutput("emptyDoneCycle", doneCyc, trig);
        end
        repeat (3) @(negedge clk);
        checkOutput("doneSticky", done, 1'b1);
    endtask

    task automatic setDelays(input int aMin, input int aMax, input int dMin, input int dMax,
                             input int sMin, input int sMax);
        arMin = aMin; arMax = aMax; rMin = dMin; rMax = dMax; tMin = sMin; tMax = sMax;
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        halt = 1'b0;
        timeout_limit = '0;
        sig_begin = '0;
        sig_end = '0;
        applyReset();
        checkResetState("reset");

        setDelays(0, 0, 0, 0, 0, 0);
        errPct = 0; errIdx = -1;
        applyStimulus(32'h100, 32'h110, 20, 0);
        applyStimulus(32'h100, 32'h110, 0, 50);
        applyStimulus(32'h200, 32'h200, 5, 0);
        applyStimulus(32'h300, 32'h30C, 10, 10);
        applyStimulus(32'h400, 32'h404, 0, 1);
        applyStimulus(32'h503, 32'h512, 4, 0);

        setDelays(3, 3, 3, 3, 10, 10);
        applyStimulus(32'h100, 32'h110, 7, 0);

        setDelays(0, 0, 0, 0, 0, 0);
        errIdx = 1;
        applyStimulus(32'h600, 32'h60C, 3, 0);
        errIdx = -1;

        // Abort in the read-data phase, then rerun from the start
        setDelays(0, 0, 5, 5, 0, 0);
        sig_begin = 32'h700;
        sig_end = 32'h710;
        timeout_limit = '0;
        applyReset();
        rstn = 1'b1;
        halt = 1'b1;
        n = 0;
        while (!m_axil_rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachR", m_axil_rready, 1'b1);
        rstn = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        checkResetState("midReset");
        applyStimulus(32'h700, 32'h710, 6, 0);

        for (int it = 0; it < 25; it++) begin
            int          h, l;
            logic [31:0] b;
            setDelays(0, $urandom_range(3, 0), 0, $urandom_range(3, 0), 0, $urandom_range(4, 0));
            errPct = 20;
            b = 32'h1000 + ($urandom_range(255, 0) << 4) + $urandom_range(3, 0);
            h = $urandom_range(40, 0);
            l = $urandom_range(40, 0);
            if (h == 0 && l == 0) h = 1;
            applyStimulus(b, b + $urandom_range(28, 0), h, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
